// File: rtl/datamem_responder_if.sv
// Request/response bus between a requester (master) and the data memory responder (slave).
interface datamem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_responder.sv
// Word-addressed data memory behind a one-outstanding request/response handshake
// with fixed access latency, error checking and a saturating error counter.
module datamem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  datamem_responder_if.slave   bus,
  output logic [7:0]           err_count
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        lat_read;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          req_err;

  always_comb begin
    word_idx = lat_addr[AW+1:2];
    req_err  = (lat_addr[1:0] != 2'b00) || (|lat_addr[31:AW+2]) || (lat_read == lat_write);
  end

  // ready_q lags reset release by one edge so no accept can happen on that first edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_count <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.req_valid) begin
            lat_read  <= bus.req_read;
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            cnt       <= CNT_INIT;
            ready_q   <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            valid_q <= 1'b1;
            if (req_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              if (err_count != '1) err_count <= err_count + 8'd1;
            end else begin
              err_q <= 1'b0;
              if (lat_write) begin
                mem[word_idx] <= lat_wdata;
                rdata_q       <= '0;
              end else begin
                rdata_q <= mem[word_idx];
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: queue/array reference model checked every cycle on the
// LATENCY=2 instance, plus latency/spacing measurement on LATENCY=1 and LATENCY=15 instances.
module tb_datamem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  datamem_responder_if bm ();
  datamem_responder_if b1 ();
  datamem_responder_if b15 ();
  logic [7:0] ec_m, ec_1, ec_15;

  datamem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut_main (
    .clk(clk), .rst(rst), .bus(bm), .err_count(ec_m));
  datamem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .bus(b1), .err_count(ec_1));
  datamem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .bus(b15), .err_count(ec_15));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit edge_hi = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) edge_hi = 1'b1;
  end

  // Reference model: one pending transaction at a time, resolved when its due edge arrives
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } ent_t;

  ent_t        q[$];
  ent_t        hd;
  ent_t        nw;
  logic [31:0] model_mem [DEPTH];
  int          model_errs = 0;
  bit          resolved   = 1'b0;
  logic [31:0] exp_rdata;
  logic        exp_err;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
      model_errs = 0;
      resolved   = 1'b0;
      edge_hi    = 1'b0;
      check("rst_resp_valid", bm.resp_valid, 0);
      check("rst_req_ready", bm.req_ready, 0);
      check("rst_err_count", ec_m, 0);
    end else begin
      if (q.size() > 0 && !resolved && cyc >= q[0].due) begin
        hd = q[0];
        exp_err = (hd.addr[1:0] != 2'b00) || (hd.addr[31:2] >= DEPTH) || (hd.rd == hd.wr);
        if (exp_err) begin
          exp_rdata = '0;
          if (model_errs < 255) model_errs++;
        end else if (hd.wr) begin
          model_mem[hd.addr[9:2]] = hd.wdata;
          exp_rdata = '0;
        end else begin
          exp_rdata = model_mem[hd.addr[9:2]];
        end
        resolved = 1'b1;
      end
      check("resp_valid", bm.resp_valid, resolved);
      if (resolved) begin
        check("resp_rdata", bm.resp_rdata, exp_rdata);
        check("resp_err", bm.resp_err, exp_err);
      end
      check("err_count", ec_m, model_errs);
      check("req_ready", bm.req_ready, (q.size() == 0) && edge_hi);
      if (bm.resp_valid && bm.resp_ready && resolved) begin
        void'(q.pop_front());
        resolved = 1'b0;
      end
      if (bm.req_valid && bm.req_ready) begin
        nw.rd = bm.req_read;
        nw.wr = bm.req_write;
        nw.addr = bm.req_addr;
        nw.wdata = bm.req_wdata;
        nw.due = cyc + 1 + int'(LAT);
        q.push_back(nw);
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err);
    int n;
    @(posedge clk); #1;
    bm.req_valid = 1'b1;
    bm.req_read  = rd;
    bm.req_write = wr;
    bm.req_addr  = addr;
    bm.req_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!bm.req_ready && n < 20);
    if (!bm.req_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bm.req_valid = 1'b0;
    bm.req_read  = 1'($urandom);
    bm.req_write = 1'($urandom);
    bm.req_addr  = $urandom;
    bm.req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!bm.resp_valid && n < 40);
    if (!bm.resp_valid) check("resp_timeout", 0, 1);
    rdata = bm.resp_rdata;
    err   = bm.resp_err;
    // requests offered while a response is held back must be ignored
    repeat (hold) begin
      @(posedge clk); #1;
      bm.req_valid = 1'b1;
      bm.req_read  = 1'b0;
      bm.req_write = 1'b1;
      bm.req_addr  = 32'h10;
      bm.req_wdata = 32'h5555_AAAA;
    end
    @(posedge clk); #1;
    bm.req_valid  = 1'b0;
    bm.resp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bm.resp_valid && bm.resp_ready) && n < 5);
    @(posedge clk); #1;
    bm.resp_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        e;
  int          n_aux;

  initial begin
    bm.req_valid = 1'b0; bm.req_read = 1'b0; bm.req_write = 1'b0;
    bm.req_addr = '0; bm.req_wdata = '0; bm.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_read = 1'b0; b1.req_write = 1'b0;
    b1.req_addr = '0; b1.req_wdata = '0; b1.resp_ready = 1'b1;
    b15.req_valid = 1'b0; b15.req_read = 1'b0; b15.req_write = 1'b0;
    b15.req_addr = '0; b15.req_wdata = '0; b15.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_valid", bm.resp_valid, 0);
    check("lit_rst_rdata", bm.resp_rdata, 0);
    check("lit_rst_err", bm.resp_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("lit_ready_before_edge", bm.req_ready, 0);
    @(posedge clk); #1;
    check("lit_ready_after_edge", bm.req_ready, 1);

    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, r, e);
    check("lit_store_err", e, 0);
    check("lit_store_rdata", r, 0);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, r, e);
    check("lit_load_10", r, 32'hDEADBEEF);
    check("lit_load_10_err", e, 0);
    txn(1'b0, 1'b1, 32'h13, 32'h1111_1111, 0, r, e);
    check("lit_misaligned_err", e, 1);
    check("lit_misaligned_rdata", r, 0);
    txn(1'b0, 1'b1, 32'h400, 32'h2222_2222, 0, r, e);
    check("lit_oob_err", e, 1);
    check("lit_err_count_2", ec_m, 2);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 5, r, e);
    check("lit_backpressure_load", r, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h3FC, 32'h0BADF00D, 0, r, e);
    txn(1'b1, 1'b0, 32'h3FC, 32'h0, 0, r, e);
    check("lit_last_word", r, 32'h0BADF00D);
    txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 0, r, e);
    check("lit_high_addr_err", e, 1);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, r, e);
    check("lit_no_op_err", e, 1);
    check("lit_err_count_4", ec_m, 4);

    // reset while the store is still waiting for its access edge
    @(posedge clk); #1;
    bm.req_valid = 1'b1; bm.req_read = 1'b0; bm.req_write = 1'b1;
    bm.req_addr = 32'h20; bm.req_wdata = 32'h12345678;
    @(negedge clk);
    check("lit_abort_ready", bm.req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bm.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    txn(1'b1, 1'b0, 32'h20, 32'h0, 0, r, e);
    check("lit_aborted_store", r, 32'h0);
    check("lit_err_count_cleared", ec_m, 0);

    txn(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0, r, e);
    for (int i = 0; i < 300; i++) txn(1'b1, 1'b1, 32'h10, $urandom, 0, r, e);
    check("lit_err_count_sat", ec_m, 255);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, r, e);
    check("lit_after_illegal", r, 32'hCAFEF00D);

    // back-to-back loads on the LATENCY=1 and LATENCY=15 instances
    @(posedge clk); #1;
    b1.req_valid = 1'b1;  b1.req_read = 1'b1;  b1.req_addr = 32'h3FC;
    b15.req_valid = 1'b1; b15.req_read = 1'b1; b15.req_addr = 32'h3FC;
    begin
      int lat[2];
      int last_acc[2];
      int nlat[2];
      bit pv[2];
      bit vld[2];
      bit acc[2];
      logic [31:0] rd_a[2];
      logic        er_a[2];
      lat = '{1, 15};
      last_acc = '{-1000, -1000};
      nlat = '{0, 0};
      pv = '{1'b0, 1'b0};
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        vld[0] = b1.resp_valid;  acc[0] = b1.req_valid && b1.req_ready;
        vld[1] = b15.resp_valid; acc[1] = b15.req_valid && b15.req_ready;
        rd_a[0] = b1.resp_rdata;  er_a[0] = b1.resp_err;
        rd_a[1] = b15.resp_rdata; er_a[1] = b15.resp_err;
        for (int k = 0; k < 2; k++) begin
          if (vld[k] && !pv[k]) begin
            check($sformatf("aux%0d_latency", lat[k]), cyc - last_acc[k], lat[k]);
            check($sformatf("aux%0d_rdata", lat[k]), rd_a[k], 0);
            check($sformatf("aux%0d_err", lat[k]), er_a[k], 0);
            nlat[k]++;
          end
          pv[k] = vld[k];
          if (acc[k]) begin
            if (last_acc[k] >= 0)
              check($sformatf("aux%0d_spacing", lat[k]), cyc + 1 - last_acc[k], lat[k] + 2);
            last_acc[k] = cyc + 1;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_aux = nlat[k];
        check($sformatf("aux%0d_resp_seen", lat[k]), n_aux >= 2, 1);
      end
    end
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    b15.req_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datamem_responder.md
DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words; SHALL be a power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2, meaning cycles from request accept to response valid; SHALL be 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 req_valid  input  1  requester presents a transaction.
REQ-006 req_ready  output  1  responder can accept a transaction this cycle.
REQ-007 req_read  input  1  transaction is a load.
REQ-008 req_write  input  1  transaction is a store.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  requester takes the response.
REQ-013 resp_rdata  output  32  load data; zero for stores and errors.
REQ-014 resp_err  output  1  transaction was rejected.
REQ-015 err_count  output  8  saturating count of errored transactions.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-017 Accept: IDLE and req_valid=1 at a rising edge -> latch read, write, addr and wdata, load cnt=LATENCY-1, and go to WAIT.
REQ-018 WAIT: at each edge, if cnt=0 perform the access and go to RESP; otherwise decrement cnt.
REQ-019 Latency: a request accepted at edge N SHALL show resp_valid=1 immediately after edge N+LATENCY.
REQ-020 Error conditions, evaluated on the latched request, SHALL be:
- addr[1:0] != 0
- addr[31:2] >= DEPTH_WORDS
- read and write both 1
- read and write both 0
REQ-021 An errored transaction SHALL NOT modify storage, and SHALL produce resp_err=1 and resp_rdata=0.
REQ-022 A valid store SHALL commit wdata to word addr[31:2] on the WAIT->RESP edge, with resp_rdata=0 and resp_err=0.
REQ-023 A valid load SHALL capture the word at addr[31:2] on the WAIT->RESP edge into resp_rdata, with resp_err=0.
REQ-024 RESP: resp_valid, resp_rdata and resp_err SHALL be held stable until a rising edge with resp_ready=1, which moves the FSM to IDLE and clears resp_valid.
REQ-025 No same-cycle accept in RESP: the next request SHALL be accepted no earlier than the edge after the response handshake (min spacing LATENCY+2 cycles).
REQ-026 Changes on req_* inputs while not in IDLE SHALL be ignored.
REQ-027 err_count SHALL increment by 1 on each WAIT->RESP edge of an errored transaction and saturate at 255 (no wrap).
REQ-028 A load following a store to the same word SHALL return the stored data (no stale read).

Reset
REQ-029 rst=0 SHALL immediately set:
- FSM to IDLE, cnt=0
- resp_valid=0, resp_rdata=0, resp_err=0
- err_count=0
- all storage words to 0
REQ-030 While rst=0, req_ready SHALL be 0; it SHALL be 1 from the first edge after rst returns to 1.
REQ-031 Reset asserted in WAIT SHALL abandon the transaction; a pending store SHALL NOT commit.
REQ-032 Reset asserted in RESP SHALL drop the response without a handshake.

Verification
REQ-033 Store then load, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 edges after each accept.
REQ-034 Misaligned and out-of-range: store to 0x13, then to 0x400 (DEPTH 256) -> resp_err=1 both times, err_count=2, and a load of 0x10 is unchanged.
REQ-035 Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready=0, a concurrent req_valid is ignored; handshake -> IDLE on the next edge.
REQ-036 Reset mid-WAIT: store 0x12345678 to 0x20, assert rst in WAIT -> a subsequent load of 0x20 returns 0x00000000.
REQ-037 Saturation and illegal op: 300 requests with read=write=1 -> err_count=255, no storage changes.
REQ-038 LATENCY=1 and LATENCY=15 builds: back-to-back loads with resp_ready=1 -> accept-to-resp_valid equals LATENCY edges, spacing LATENCY+2 cycles.
